lcd_timing_ctrl: RTL and testbench
==================================

# lcd_timing_ctrl

Scanline scheduler for the whizgraphics renderer. Generates Game Boy LCD dot/line timing, sequences the renderer one line at a time via the `drawline`/`renderComplete` handshake, and publishes LY, PPU mode, the LY=LYC coincidence flag and the VBlank/STAT interrupt requests to the rest of the system. It sits between the LCDC/STAT register file and the `whizgraphics` render datapath.

## Interface
- `DOTS_PER_LINE`, 456: dots per scanline (line length).
- `TOTAL_LINES`, 154: lines per frame, including VBlank.
- `VISIBLE_LINES`, 144: lines that are rendered.
- `OAM_DOTS`, 80: mode 2 length, in dots.
- `MIN_XFER_DOTS`, 172: minimum mode 3 length, in dots.

- `clk`  in  1  system clock; one dot per cycle.
- `reset`  in  1  synchronous, active-high reset.
- `lcd_enable`  in  1  LCDC bit 7. Low holds the block idle.
- `lyc`  in  8  LYC compare value.
- `stat_en`  in  4  STAT source enables. Bit 0: mode 0. Bit 1: mode 1. Bit 2: mode 2. Bit 3: LYC.
- `renderComplete`  in  1  renderer reports that the current line has finished.
- `drawline`  out  1  one-cycle pulse that starts rendering of line `ly`.
- `ly`  out  8  current line number.
- `mode`  out  2  0 = HBlank, 1 = VBlank, 2 = OAM scan, 3 = transfer.
- `lyc_match`  out  1  registered (`ly == lyc`).
- `vblank_irq`  out  1  one-cycle VBlank request pulse.
- `stat_irq`  out  1  one-cycle STAT request pulse.
- `overrun`  out  1  sticky flag: the renderer missed its line deadline.

## Operation
- **Internal state:** a 9-bit `dot` counter (0..DOTS_PER_LINE-1), `ly`, `mode`, and a `done` latch.
- **Idle** (`reset`, or `lcd_enable` low):
  - `dot=0`, `ly=0`, `mode=0`, `done=0`, `overrun=0`.
  - All pulses are held at 0. `lyc_match` keeps tracking (`0 == lyc`).
- **Enable:** on the first enabled cycle the block enters `dot=0`, `ly=0`, `mode=2`.
- **Visible lines** (`ly < VISIBLE_LINES`):
  - Mode 2 while `dot < OAM_DOTS`.
  - When `dot` reaches `OAM_DOTS`: `mode` becomes 3, `drawline` pulses for exactly one cycle (the same cycle `mode` becomes 3), and `done` clears.
  - `renderComplete` is sampled only while `mode==3`. It sets `done`, including on the `drawline` cycle. `renderComplete` in any other mode is ignored.
  - Mode 3 to mode 0: on the first cycle where `done` is set (or `renderComplete` is high) and `dot >= OAM_DOTS+MIN_XFER_DOTS-1`. The change takes effect the next cycle.
  - Mode 0 continues until the line wraps.
- **Line wrap** (`dot == DOTS_PER_LINE-1`): `dot` goes to 0 and `ly` increments.
  - If `mode==3` at this point, `overrun` sets (sticky) and the line advances regardless.
  - New `ly == VISIBLE_LINES`: `mode` becomes 1 and `vblank_irq` pulses one cycle.
  - Old `ly == TOTAL_LINES-1`: `ly` becomes 0 and `mode` becomes 2.
  - Any other new visible line: `mode` becomes 2.
- **VBlank lines:** `mode` stays 1. No `drawline` is issued.
- **Arithmetic:** `ly` is unsigned 8-bit. `lyc_match` updates in the same cycle as `ly`/`lyc`.
- **Priority:** `reset` beats `lcd_enable` low, which beats all timing events.
  - Reset or disable mid-line aborts the line with no `drawline` or IRQ.
  - A `renderComplete` arriving after an abort is ignored.

## Timing
- **Line:** exactly DOTS_PER_LINE cycles. **Frame:** DOTS_PER_LINE × TOTAL_LINES = 70224 cycles.
- **`drawline`** is registered. Measured from the line's `dot=0` cycle, it rises OAM_DOTS cycles later (cycle 80).
- **Earliest mode 0:** dot 252 (OAM_DOTS+MIN_XFER_DOTS).
  - If `renderComplete` arrives at dot d ≥ 251, mode 0 begins at d+1.
  - If `renderComplete` never arrives, mode 3 persists until the wrap and `overrun` sets.
- **`vblank_irq`:** asserted on the cycle where `ly` first reads 144.
- **`stat_irq`:** internal line = OR of `stat_en[i]` with the matching condition (mode 0, 1, 2 or `lyc_match`).
  - `stat_irq` pulses one cycle after each rising edge of that line ("STAT blocking": no retrigger while the line stays high).
  - The edge detector resets to 0.
- **All outputs are registered.** Reset values: every output 0.

## Configuration
- **`LCD_STAT_IRQ_EN`**
  - Defined: the STAT line, edge detector and `stat_irq` are built as described above.
  - Undefined: that logic is removed and `stat_irq` is tied to 0.
  - Everything else is unchanged either way, including `lyc_match`, which always remains.

## Test plan
- **Nominal line:** enable, renderer answers `renderComplete` 100 cycles after `drawline`.
  - `drawline` at dot 80, `mode` 2→3 at dot 80, 3→0 at dot 252.
  - `ly` 0→1 at cycle 456. `overrun` stays 0.
- **Late render:** `renderComplete` at dot 400.
  - Mode 0 starts at dot 401. The line still wraps at 456.
- **Missing render:** `renderComplete` never asserted.
  - Mode 3 persists through dot 455, then `overrun=1` and `ly=1`, `mode=2`.
  - `overrun` stays 1 until `lcd_enable` drops.
- **Frame:** run 70224 cycles with a prompt renderer.
  - Exactly 144 `drawline` pulses.
  - `vblank_irq` pulse when `ly=144`, `mode=1` on lines 144–153.
  - `ly` wraps 153→0 with `mode=2`.
- **STAT:** `lyc=5`, `stat_en=4'b1001`.
  - `stat_irq` pulses at the `ly=5` entry.
  - No extra pulse at the line 5 mode 0 entry, because the line is already high.
  - Under `LCD_STAT_IRQ_EN` undefined, `stat_irq` stays 0.
- **Abort:** assert `reset` at dot 200 of line 10 while `renderComplete` pulses in the same cycle.
  - Next cycle: all outputs 0.
  - Re-enable gives `drawline` at cycle 80 with `ly=0`.

Source files
------------

// File: rtl/lcd_timing_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_if
// Description : Control/status bundle between the LCDC/STAT register file,
//               the whizgraphics renderer and the LCD timing controller.
//               "master" is the register-file/renderer side; "slave" is the
//               timing controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_timing_if;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_en;
    logic       renderComplete;
    logic       drawline;
    logic [7:0] ly;
    logic [1:0] mode;
    logic       lyc_match;
    logic       vblank_irq;
    logic       stat_irq;
    logic       overrun;

    modport master (
        output lcd_enable, lyc, stat_en, renderComplete,
        input  drawline, ly, mode, lyc_match, vblank_irq, stat_irq, overrun
    );

    modport slave (
        input  lcd_enable, lyc, stat_en, renderComplete,
        output drawline, ly, mode, lyc_match, vblank_irq, stat_irq, overrun
    );
endinterface
`default_nettype wire

// File: rtl/lcd_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_ctrl
// Description : Game Boy LCD dot/line scheduler. Counts dots and lines,
//               walks the PPU mode sequence, hands one line at a time to the
//               renderer (drawline / renderComplete) and raises LY=LYC,
//               VBlank and STAT requests. All outputs are registered.
//               Optional feature macro: LCD_STAT_IRQ_EN builds the STAT
//               interrupt line and its edge detector; otherwise stat_irq = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing_ctrl #(
    parameter int DOTS_PER_LINE = 456,
    parameter int TOTAL_LINES   = 154,
    parameter int VISIBLE_LINES = 144,
    parameter int OAM_DOTS      = 80,
    parameter int MIN_XFER_DOTS = 172
) (
    input  wire logic      clk,
    input  wire logic      reset,
    lcd_timing_if.slave    bus
);

    // Comparison points, pre-sized to the counters they are compared with.
    localparam logic [8:0] c_DOT_LAST     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] c_OAM_LAST     = 9'(OAM_DOTS - 1);
    localparam logic [8:0] c_XFER_MIN_END = 9'(OAM_DOTS + MIN_XFER_DOTS - 1);
    localparam logic [7:0] c_LY_VBLANK    = 8'(VISIBLE_LINES);
    localparam logic [7:0] c_LY_LAST      = 8'(TOTAL_LINES - 1);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } mode_t;

    // Registered state
    logic [8:0] r_dot;
    logic [7:0] r_ly;
    mode_t      r_mode;
    logic       r_done;
    logic       r_active;
    logic       r_overrun;
    logic       r_drawline;
    logic       r_vblank_irq;
    logic       r_lyc_match;

    // Next-state values
    logic [8:0] w_dot_nxt;
    logic [7:0] w_ly_nxt;
    mode_t      w_mode_nxt;
    logic       w_done_nxt;
    logic       w_active_nxt;
    logic       w_overrun_nxt;
    logic       w_drawline_nxt;
    logic       w_vblank_nxt;

    logic [7:0] w_ly_inc;
    logic       w_rc;

    assign w_ly_inc = r_ly + 8'd1;
    // The renderer is only listened to while a transfer is in progress.
    assign w_rc     = (r_mode == MODE_XFER) && bus.renderComplete;

    // State register; reset and disable both return to the idle state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dot        <= 9'd0;
            r_ly         <= 8'd0;
            r_mode       <= MODE_HBLANK;
            r_done       <= 1'b0;
            r_active     <= 1'b0;
            r_overrun    <= 1'b0;
            r_drawline   <= 1'b0;
            r_vblank_irq <= 1'b0;
            r_lyc_match  <= 1'b0;
        end else begin
            r_dot        <= w_dot_nxt;
            r_ly         <= w_ly_nxt;
            r_mode       <= w_mode_nxt;
            r_done       <= w_done_nxt;
            r_active     <= w_active_nxt;
            r_overrun    <= w_overrun_nxt;
            r_drawline   <= w_drawline_nxt;
            r_vblank_irq <= w_vblank_nxt;
            r_lyc_match  <= (r_ly == bus.lyc);
        end
    end

    // Dot/line counting, mode sequencing and the drawline/VBlank pulses.
    always_comb begin
        w_dot_nxt      = r_dot;
        w_ly_nxt       = r_ly;
        w_mode_nxt     = r_mode;
        w_done_nxt     = r_done;
        w_active_nxt   = r_active;
        w_overrun_nxt  = r_overrun;
        w_drawline_nxt = 1'b0;
        w_vblank_nxt   = 1'b0;

        if (!bus.lcd_enable) begin
            // Disabled: hold idle, drop any line in progress.
            w_dot_nxt     = 9'd0;
            w_ly_nxt      = 8'd0;
            w_mode_nxt    = MODE_HBLANK;
            w_done_nxt    = 1'b0;
            w_active_nxt  = 1'b0;
            w_overrun_nxt = 1'b0;
        end else if (!r_active) begin
            // First enabled cycle: start line 0 in OAM scan.
            w_active_nxt = 1'b1;
            w_dot_nxt    = 9'd0;
            w_ly_nxt     = 8'd0;
            w_mode_nxt   = MODE_OAM;
            w_done_nxt   = 1'b0;
        end else begin
            if (w_rc) begin
                w_done_nxt = 1'b1;
            end

            if (r_dot == c_DOT_LAST) begin
                // Line wrap: a transfer still running here missed its deadline.
                w_dot_nxt = 9'd0;
                if (r_mode == MODE_XFER) begin
                    w_overrun_nxt = 1'b1;
                end
                if (r_ly == c_LY_LAST) begin
                    w_ly_nxt   = 8'd0;
                    w_mode_nxt = MODE_OAM;
                end else begin
                    w_ly_nxt = w_ly_inc;
                    if (w_ly_inc == c_LY_VBLANK) begin
                        w_mode_nxt   = MODE_VBLANK;
                        w_vblank_nxt = 1'b1;
                    end else if (w_ly_inc < c_LY_VBLANK) begin
                        w_mode_nxt = MODE_OAM;
                    end
                end
            end else begin
                w_dot_nxt = r_dot + 9'd1;
                case (r_mode)
                    MODE_OAM: begin
                        if (r_dot == c_OAM_LAST) begin
                            w_mode_nxt     = MODE_XFER;
                            w_drawline_nxt = 1'b1;
                            w_done_nxt     = 1'b0;
                        end
                    end
                    MODE_XFER: begin
                        // Leave transfer once the renderer is done and the
                        // minimum transfer length has elapsed.
                        if ((r_done || w_rc) && (r_dot >= c_XFER_MIN_END)) begin
                            w_mode_nxt = MODE_HBLANK;
                        end
                    end
                    default: begin
                        w_mode_nxt = r_mode;
                    end
                endcase
            end
        end
    end

    assign bus.drawline   = r_drawline;
    assign bus.ly         = r_ly;
    assign bus.mode       = r_mode;
    assign bus.lyc_match  = r_lyc_match;
    assign bus.vblank_irq = r_vblank_irq;
    assign bus.overrun    = r_overrun;

`ifdef LCD_STAT_IRQ_EN
    logic w_stat_line;
    logic r_stat_prev;
    logic r_stat_irq;

    // Combined STAT request level from the enabled sources.
    always_comb begin
        w_stat_line = (bus.stat_en[0] && (r_mode == MODE_HBLANK)) ||
                      (bus.stat_en[1] && (r_mode == MODE_VBLANK)) ||
                      (bus.stat_en[2] && (r_mode == MODE_OAM))    ||
                      (bus.stat_en[3] && r_lyc_match);
    end

    // Rising-edge detector: one pulse per low-to-high transition of the line.
    always_ff @(posedge clk) begin
        if (reset || !bus.lcd_enable || !r_active) begin
            r_stat_prev <= 1'b0;
            r_stat_irq  <= 1'b0;
        end else begin
            r_stat_prev <= w_stat_line;
            r_stat_irq  <= w_stat_line && !r_stat_prev;
        end
    end

    assign bus.stat_irq = r_stat_irq;
`else
    logic w_unused_stat_en;
    assign w_unused_stat_en = ^bus.stat_en;
    assign bus.stat_irq     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_timing_ctrl
// Description : Self-checking bench for lcd_timing_ctrl: per-line render
//               vectors, a full frame, STAT pulses and a mid-line abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_timing_ctrl;

    logic clk = 1'b0;
    logic reset;

    lcd_timing_if bus();

    lcd_timing_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rc_dot;   // dot at which renderComplete is driven, -1 = never
        int exp_m0;   // expected dot of mode 3 -> 0, -1 = never
        bit exp_ovr;  // expected overrun after the line wraps
    } vec_t;

    typedef struct {
        int kind;     // 0 = drawline, 1 = mode 0 entry
        int dot;
    } ev_t;

    vec_t vecs[8];
    ev_t  q_ev[$];
    int   q_stat[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_drawline"},  int'(bus.drawline),   0);
        check({tag, "_ly"},        int'(bus.ly),         0);
        check({tag, "_mode"},      int'(bus.mode),       0);
        check({tag, "_lyc_match"}, int'(bus.lyc_match),  0);
        check({tag, "_vblank"},    int'(bus.vblank_irq), 0);
        check({tag, "_stat"},      int'(bus.stat_irq),   0);
        check({tag, "_overrun"},   int'(bus.overrun),    0);
    endtask

    // Leaves the bench on the first active cycle (line 0, dot 0).
    task automatic start();
        bus.renderComplete = 1'b0;
        reset              = 1'b1;
        bus.lcd_enable     = 1'b0;
        repeat (2) tick();
        check_idle("rst");
        reset          = 1'b0;
        bus.lcd_enable = 1'b1;
        tick();
        check("start_mode", int'(bus.mode), 2);
        check("start_ly",   int'(bus.ly),   0);
    endtask

    task automatic ev_seen(input int idx, input int kind, input int dot);
        ev_t e;
        if (q_ev.size() == 0) begin
            check($sformatf("v%0d_unexpected_ev%0d_at", idx, kind), dot, -1);
        end else begin
            e = q_ev.pop_front();
            check($sformatf("v%0d_ev_kind", idx), kind, e.kind);
            check($sformatf("v%0d_ev%0d_dot", idx, kind), dot, e.dot);
        end
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int prev_mode;
        lyc_set(200);
        bus.stat_en = 4'b0000;
        start();
        q_ev.delete();
        q_ev.push_back('{0, 80});
        if (v.exp_m0 >= 0) q_ev.push_back('{1, v.exp_m0});
        for (int d = 0; d < 456; d++) begin
            bus.renderComplete = (d == v.rc_dot);
            prev_mode = int'(bus.mode);
            tick();
            if (d + 1 == 79) check($sformatf("v%0d_mode_d79", idx), int'(bus.mode), 2);
            if (d + 1 == 80) check($sformatf("v%0d_mode_d80", idx), int'(bus.mode), 3);
            if (bus.drawline) ev_seen(idx, 0, d + 1);
            if (prev_mode == 3 && bus.mode == 2'd0) ev_seen(idx, 1, d + 1);
        end
        bus.renderComplete = 1'b0;
        check($sformatf("v%0d_wrap_ly", idx),      int'(bus.ly),      1);
        check($sformatf("v%0d_wrap_mode", idx),    int'(bus.mode),    2);
        check($sformatf("v%0d_wrap_overrun", idx), int'(bus.overrun), int'(v.exp_ovr));
        check($sformatf("v%0d_missing_events", idx), q_ev.size(), 0);
        repeat (100) tick();
        check($sformatf("v%0d_overrun_sticky", idx), int'(bus.overrun), int'(v.exp_ovr));
        bus.lcd_enable = 1'b0;
        tick();
        check($sformatf("v%0d_dis_overrun", idx), int'(bus.overrun), 0);
        check($sformatf("v%0d_dis_ly", idx),      int'(bus.ly),      0);
        check($sformatf("v%0d_dis_mode", idx),    int'(bus.mode),    0);
    endtask

    task automatic lyc_set(input int val);
        bus.lyc = 8'(val);
    endtask

    initial begin
        int n_draw, n_vb, n_stat, ly_bad, mode_bad, lm_bad, exp_ly, first_draw;
        bit exp_lm;

        vecs[0] = '{180, 252, 1'b0};  // nominal: 100 cycles after drawline
        vecs[1] = '{400, 401, 1'b0};  // late render
        vecs[2] = '{251, 252, 1'b0};  // exactly at the minimum-length boundary
        vecs[3] = '{250, 252, 1'b0};  // early: waits for minimum length
        vecs[4] = '{80,  252, 1'b0};  // on the drawline cycle itself
        vecs[5] = '{60,  -1,  1'b1};  // during OAM scan: ignored
        vecs[6] = '{-1,  -1,  1'b1};  // missing render
        vecs[7] = '{454, 455, 1'b0};  // last chance before wrap

        reset              = 1'b1;
        bus.lcd_enable     = 1'b0;
        bus.lyc            = 8'd200;
        bus.stat_en        = 4'b0000;
        bus.renderComplete = 1'b0;

        for (int i = 0; i < 8; i++) run_vector(i, vecs[i]);

        // Full frame with a prompt renderer, STAT on mode 0 and LYC=5.
        lyc_set(5);
        bus.stat_en = 4'b1001;
        start();
        q_stat.delete();
`ifdef LCD_STAT_IRQ_EN
        for (int l = 0; l < 144; l++) q_stat.push_back(l == 5 ? l * 456 + 2 : l * 456 + 253);
`endif
        n_draw = 0; n_vb = 0; n_stat = 0; ly_bad = 0; mode_bad = 0; lm_bad = 0;
        for (int c = 1; c <= 70224; c++) begin
            bus.renderComplete = bus.drawline;
            tick();
            exp_ly = (c / 456) % 154;
            exp_lm = (((c - 1) / 456) % 154) == 5;
            if (int'(bus.ly) != exp_ly) ly_bad++;
            if ((exp_ly >= 144) != (bus.mode == 2'd1)) mode_bad++;
            if (bus.lyc_match != exp_lm) lm_bad++;
            if (bus.drawline) n_draw++;
            if (bus.vblank_irq) begin
                n_vb++;
                check("frame_vblank_cycle", c, 65664);
                check("frame_vblank_ly", int'(bus.ly), 144);
            end
            if (bus.stat_irq) begin
                n_stat++;
                if (q_stat.size() == 0) check("stat_unexpected_at", c, -1);
                else check("stat_pulse_cycle", c, q_stat.pop_front());
            end
        end
        bus.renderComplete = 1'b0;
        check("frame_drawlines",   n_draw,   144);
        check("frame_vblank_cnt",  n_vb,     1);
        check("frame_ly_errors",   ly_bad,   0);
        check("frame_mode1_errs",  mode_bad, 0);
        check("frame_lyc_errs",    lm_bad,   0);
        check("frame_end_ly",      int'(bus.ly),   0);
        check("frame_end_mode",    int'(bus.mode), 2);
        check("frame_overrun",     int'(bus.overrun), 0);
        check("stat_missing",      q_stat.size(), 0);
`ifdef LCD_STAT_IRQ_EN
        check("stat_count", n_stat, 144);
`else
        check("stat_count", n_stat, 0);
`endif

        // Abort at line 10 dot 200 with renderComplete in the same cycle.
        lyc_set(5);
        bus.stat_en = 4'b0000;
        start();
        for (int c = 1; c <= 4760; c++) begin
            bus.renderComplete = bus.drawline;
            tick();
        end
        check("abort_pre_ly",   int'(bus.ly),   10);
        check("abort_pre_mode", int'(bus.mode), 3);
        reset              = 1'b1;
        bus.renderComplete = 1'b1;
        tick();
        check_idle("abort");
        reset              = 1'b0;
        bus.renderComplete = 1'b0;
        tick();
        check("reen_mode", int'(bus.mode), 2);
        first_draw = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (bus.drawline && first_draw < 0) begin
                first_draw = c;
                check("reen_draw_ly", int'(bus.ly), 0);
            end
        end
        check("reen_draw_cycle", first_draw, 80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
